rv_stim_gen: RTL and testbench
==============================

Name: rv_stim_gen

Overview:
- Synthesizable random RISC-V instruction stimulus generator for the Sodor5 verification harness; drives the core's imem response data.
- Emits a mix of I-type ALU, store and load instructions, with configurable class weights, register window, immediate masks and instruction budget.
- Seeded 64-bit LFSR makes every run reproducible. A valid/ready handshake lets the consumer stall without losing or repeating instructions.

Parameters:
- SEED, 64'h0000_0000_0000_0104: LFSR reset value; zero is replaced by 1.
- W_ALU, 8: ALU-immediate class weight, out of 16.
- W_ST, 4: store class weight, out of 16.
- W_RT, 0: R-type class weight; only used with RVGEN_RTYPE_EN.
- REG_MASK, 5'h1F: mask applied to rd/rs1/rs2 fields.
- MEM_IMM_MASK, 12'hFFF: mask applied to load/store offsets.
- LD_F3_MASK, 3'b100: mask applied to load funct3.
- ST_F3, 3'b000: fixed store funct3.
- NOP_WARMUP, 4: accepted NOPs emitted before random stream.
- CNT_W, 32: instruction counter width.
- NUM_INSTR, 0: random-instruction budget; 0 = unlimited.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low reset.
- out_ready, in, 1: consumer accepts out_instr this cycle.
- seed_load, in, 1: reload LFSR from seed_in and restart.
- seed_in, in, 64: runtime seed.
- out_valid, out, 1: out_instr valid.
- out_instr, out, 32: instruction word.
- out_class, out, 2: 0 NOP, 1 ALU, 2 STORE, 3 LOAD/RTYPE (see below).
- instr_count, out, CNT_W: random instructions accepted.
- done, out, 1: budget exhausted.

Behaviour:
- Handshake:
  - A handshake (hs) is out_valid & out_ready.
  - out_instr and out_class are registered and held stable until hs.
  - Handshakes are allowed back-to-back, one per cycle.
- Reset (reset==0 at posedge):
  - out_valid=0, out_instr=32'h00000013, out_class=0, instr_count=0, done=0.
  - lfsr=SEED (1 if SEED==0). FSM goes to WARM with warm_cnt=0.
- FSM states: WARM, RUN, DONE.
- WARM:
  - out_valid=1 from the first cycle after reset deasserts; emits NOP.
  - Each hs increments warm_cnt.
  - On the hs where warm_cnt==NOP_WARMUP-1: advance LFSR, load the first random instruction, go to RUN.
  - NOP_WARMUP=0: the first random instruction is loaded on the first post-reset cycle and the FSM enters RUN directly.
- RUN:
  - Each hs increments instr_count (saturating) and advances the LFSR one step.
  - The next instruction is built from the new LFSR value and appears the next cycle (latency 1 from hs).
  - If NUM_INSTR!=0 and the incremented count equals NUM_INSTR: go to DONE instead, load NOP, set done=1.
- DONE:
  - out_valid=1, NOP forever, done=1, counter frozen.
- LFSR:
  - Fibonacci, taps x^64+x^63+x^61+x^60+1, shift left, feedback into bit 0.
  - Advances only on the events above.
- Field carve from new state r:
  - sel=r[3:0], rd=r[8:4]&REG_MASK, rs1=r[13:9]&REG_MASK, rs2=r[18:14]&REG_MASK.
  - f3=r[21:19], imm=r[33:22], lb=r[34], f7b=r[35].
- Class select:
  - sel<W_ALU -> ALU.
  - sel<W_ALU+W_ST -> STORE.
  - (RTYPE_EN) sel<W_ALU+W_ST+W_RT -> RTYPE.
  - Otherwise LOAD. Weight sums >16 simply starve later classes.
- ALU (opcode 0010011): {imm', rs1, f3, rd, 0010011}.
  - f3==1: imm'=imm&12'h01F.
  - f3==5: imm'=imm&12'h41F.
  - Otherwise imm'=imm.
- STORE (opcode 0100011):
  - m=imm&MEM_IMM_MASK.
  - {m[11:5], rs2, rs1, ST_F3, m[4:0], 0100011}.
- LOAD (opcode 0000011):
  - {imm&MEM_IMM_MASK, rs1, {lb,2'b00}&LD_F3_MASK, rd, 0000011}.
- seed_load (reset high):
  - lfsr=seed_in (1 if zero), instr_count=0, done=0, warm_cnt=0, out_instr=NOP, out_class=0, FSM to WARM. out_valid stays 1.
  - Takes priority over a simultaneous hs; that hs still completes for the consumer, but is not counted and does not advance the LFSR.
- Priority: reset > seed_load > hs.
- Reset asserted mid-stall discards the pending instruction.

Optional Feature:
- Macro RVGEN_RTYPE_EN.
- Defined: the RTYPE class is enabled; out_class=3 covers both classes, split by opcode.
  - Encoding {0,f7b,5'b0, rs2, rs1, f3, rd, 0110011}.
  - f7b is forced to 0 unless f3 is 0 (ADD/SUB) or 5 (SRL/SRA).
- Undefined: W_RT is ignored and no R-type opcodes are ever produced.

Decomposition:
- Package rv_stim_pkg:
  - opcode constants (OP_IMM, OP_STORE, OP_LOAD, OP_REG), NOP_INSTR=32'h00000013;
  - class enum; state enum; LFSR tap constant.
- Sub-module rv_stim_lfsr64: seedable LFSR with load, step and zero-seed guard.
- Encoding is a combinational function in the top module.

Test Plan:
- Reset held 3 cycles, then out_ready=1 with defaults -> 4 NOPs with out_valid=1, then the first non-NOP word; instr_count=1 after its hs.
- out_ready low 5 cycles mid-RUN -> out_instr stable for all 5 cycles, instr_count unchanged, LFSR unchanged; the next word appears 1 cycle after ready returns.
- NUM_INSTR=10, ready=1 -> exactly 10 random words accepted, then done=1, NOP forever, instr_count=10.
- W_ALU=16 -> all words have opcode 0010011. Every f3=1 word has imm[11:5]=0; every f3=5 word has imm[11:5] in {0x00,0x20}.
- W_ALU=0, W_ST=0, LD_F3_MASK=3'b100 -> loads only, funct3 in {0,4}. REG_MASK=5'h07 -> rd and rs1 <=7.
- seed_load with seed_in=0 coincident with hs in RUN -> LFSR=1, count=0, WARM restarted. The stream matches a fresh run with SEED=1.

Source files
------------

// File: rtl/rv_stim_pkg.sv
// Shared constants, types and LFSR helpers for the rv_stim_gen instruction
// stimulus generator.
package rv_stim_pkg;

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Feedback taps for x^64 + x^63 + x^61 + x^60 + 1 (state bits 63, 62, 60, 59).
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Class 3 is shared by loads and (when enabled) R-type words; the opcode tells them apart.
    typedef enum logic [1:0] {
        CLS_NOP   = 2'd0,
        CLS_ALU   = 2'd1,
        CLS_STORE = 2'd2,
        CLS_LOAD  = 2'd3
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_WARM,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        instr_class_e cls;
        logic [31:0]  instr;
    } enc_t;

    function automatic logic [63:0] lfsr_advance(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero state would lock the LFSR up, so zero seeds become 1.
    function automatic logic [63:0] seed_guard(input logic [63:0] s);
        return (s == '0) ? 64'd1 : s;
    endfunction

endpackage

// File: rtl/rv_stim_lfsr64.sv
// Seedable 64-bit Fibonacci LFSR with load, step and zero-seed guard.
// next_state exposes the value the register takes on the following step.
module rv_stim_lfsr64
    import rv_stim_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h0000_0000_0000_0104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        step,
    output logic [63:0] next_state
);

    logic [63:0] state;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= seed_guard(SEED);
        end else if (load) begin
            state <= seed_guard(seed);
        end else if (step) begin
            state <= lfsr_advance(state);
        end
    end

    assign next_state = lfsr_advance(state);

endmodule

// File: rtl/rv_stim_gen.sv
// Random RISC-V ALU-immediate/store/load stimulus generator with valid/ready output.
// Define RVGEN_RTYPE_EN to add an R-type class weighted by W_RT.
module rv_stim_gen
    import rv_stim_pkg::*;
#(
    parameter logic [63:0] SEED         = 64'h0000_0000_0000_0104,
    parameter int          W_ALU        = 8,
    parameter int          W_ST         = 4,
    parameter int          W_RT         = 0,
    parameter logic [4:0]  REG_MASK     = 5'h1F,
    parameter logic [11:0] MEM_IMM_MASK = 12'hFFF,
    parameter logic [2:0]  LD_F3_MASK   = 3'b100,
    parameter logic [2:0]  ST_F3        = 3'b000,
    parameter int          NOP_WARMUP   = 4,
    parameter int          CNT_W        = 32,
    parameter int unsigned NUM_INSTR    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out_ready,
    input  logic             seed_load,
    input  logic [63:0]      seed_in,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_class,
    output logic [CNT_W-1:0] instr_count,
    output logic             done
);

`ifdef RVGEN_RTYPE_EN
    localparam int         CARVE_W = 36;
    localparam logic [5:0] LIM_RT  = 6'(W_ALU + W_ST + W_RT);
`else
    localparam int         CARVE_W = 35;
`endif
    localparam logic [5:0]  LIM_ALU   = 6'(W_ALU);
    localparam logic [5:0]  LIM_ST    = 6'(W_ALU + W_ST);
    localparam logic [15:0] WARM_LAST = 16'(NOP_WARMUP - 1);

    function automatic enc_t encode(input logic [CARVE_W-1:0] r);
        logic [3:0]  sel;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm, m, imm_alu;
        enc_t        e;
        sel = r[3:0];
        rd  = r[8:4] & REG_MASK;
        rs1 = r[13:9] & REG_MASK;
        rs2 = r[18:14] & REG_MASK;
        f3  = r[21:19];
        imm = r[33:22];
        m   = imm & MEM_IMM_MASK;
        // Shift-immediates keep only a legal shamt (plus the SRAI bit for f3==5).
        case (f3)
            3'd1:    imm_alu = imm & 12'h01F;
            3'd5:    imm_alu = imm & 12'h41F;
            default: imm_alu = imm;
        endcase
        if ({2'b00, sel} < LIM_ALU) begin
            e.cls   = CLS_ALU;
            e.instr = {imm_alu, rs1, f3, rd, OP_IMM};
        end else if ({2'b00, sel} < LIM_ST) begin
            e.cls   = CLS_STORE;
            e.instr = {m[11:5], rs2, rs1, ST_F3, m[4:0], OP_STORE};
`ifdef RVGEN_RTYPE_EN
        end else if ({2'b00, sel} < LIM_RT) begin
            e.cls   = CLS_LOAD;
            e.instr = {1'b0, r[35] & ((f3 == 3'd0) | (f3 == 3'd5)), 5'b00000,
                       rs2, rs1, f3, rd, OP_REG};
`endif
        end else begin
            e.cls   = CLS_LOAD;
            e.instr = {m, rs1, {r[34], 2'b00} & LD_F3_MASK, rd, OP_LOAD};
        end
        return e;
    endfunction

    state_e          state;
    logic [15:0]     warm_cnt;
    logic [63:0]     lfsr_next;
    logic            hs;
    logic            warm_exit;
    logic            lfsr_step;
    logic            budget_hit;
    logic [CNT_W-1:0] count_inc;
    enc_t            enc;
    logic            unused_lfsr_hi;

    assign hs         = out_valid & out_ready;
    assign warm_exit  = (NOP_WARMUP == 0) || (hs && (warm_cnt == WARM_LAST));
    assign lfsr_step  = !seed_load && (((state == ST_WARM) && warm_exit) ||
                                       ((state == ST_RUN) && hs));
    assign count_inc  = (instr_count == '1) ? instr_count : instr_count + CNT_W'(1);
    assign budget_hit = (NUM_INSTR != 0) && (count_inc == CNT_W'(NUM_INSTR));
    assign enc        = encode(lfsr_next[CARVE_W-1:0]);
`ifdef RVGEN_RTYPE_EN
    assign unused_lfsr_hi = ^lfsr_next[63:CARVE_W];
`else
    assign unused_lfsr_hi = ^{lfsr_next[63:CARVE_W], 6'(W_RT)};
`endif

    rv_stim_lfsr64 #(.SEED(SEED)) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (seed_load),
        .seed       (seed_in),
        .step       (lfsr_step),
        .next_state (lfsr_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_WARM;
            warm_cnt    <= '0;
            out_valid   <= 1'b0;
            out_instr   <= NOP_INSTR;
            out_class   <= CLS_NOP;
            instr_count <= '0;
            done        <= 1'b0;
        end else if (seed_load) begin
            // A coincident handshake completes for the consumer but is not counted.
            state       <= ST_WARM;
            warm_cnt    <= '0;
            out_valid   <= 1'b1;
            out_instr   <= NOP_INSTR;
            out_class   <= CLS_NOP;
            instr_count <= '0;
            done        <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            case (state)
                ST_WARM: begin
                    if (warm_exit) begin
                        out_instr <= enc.instr;
                        out_class <= enc.cls;
                        state     <= ST_RUN;
                    end else if (hs) begin
                        warm_cnt <= warm_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        instr_count <= count_inc;
                        if (budget_hit) begin
                            out_instr <= NOP_INSTR;
                            out_class <= CLS_NOP;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            out_instr <= enc.instr;
                            out_class <= enc.cls;
                        end
                    end
                end
                ST_DONE: ;
                default: state <= ST_WARM;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_stim_gen.sv
// Scoreboard bench for rv_stim_gen: directed expected words are queued and a
// negedge monitor pops and compares them on every handshake.
module tb_rv_stim_gen;

    typedef struct packed {
        logic [1:0]  cls;
        logic [31:0] instr;
    } word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load;
    logic [63:0] seed_in;
    logic        rdy_m, rdy_d, rdy_a, rdy_l;
    logic        no_load = 1'b0;
    logic [63:0] no_seed = 64'd0;

    logic m_valid, d_valid, a_valid, l_valid;
    logic m_done, d_done, a_done, l_done;
    logic [31:0] m_instr, d_instr, a_instr, l_instr;
    logic [1:0]  m_class, d_class, a_class, l_class;
    logic [31:0] m_count, d_count, a_count, l_count;

    int n_checks = 0;
    int n_fails  = 0;
    int m_pops   = 0;
    int d_rand   = 0;
    int a_words  = 0;
    int a_f3_1   = 0;
    int l_words  = 0;
    word_t       exp_q[$];
    logic [63:0] m_lfsr;

    always #5 clk = ~clk;

    rv_stim_gen u_main (
        .clk(clk), .reset(reset), .out_ready(rdy_m), .seed_load(seed_load), .seed_in(seed_in),
        .out_valid(m_valid), .out_instr(m_instr), .out_class(m_class),
        .instr_count(m_count), .done(m_done));

    rv_stim_gen #(.NUM_INSTR(10)) u_done (
        .clk(clk), .reset(reset), .out_ready(rdy_d), .seed_load(no_load), .seed_in(no_seed),
        .out_valid(d_valid), .out_instr(d_instr), .out_class(d_class),
        .instr_count(d_count), .done(d_done));

    rv_stim_gen #(.W_ALU(16)) u_alu (
        .clk(clk), .reset(reset), .out_ready(rdy_a), .seed_load(no_load), .seed_in(no_seed),
        .out_valid(a_valid), .out_instr(a_instr), .out_class(a_class),
        .instr_count(a_count), .done(a_done));

    rv_stim_gen #(.W_ALU(0), .W_ST(0), .REG_MASK(5'h07), .LD_F3_MASK(3'b100)) u_ld (
        .clk(clk), .reset(reset), .out_ready(rdy_l), .seed_load(no_load), .seed_in(no_seed),
        .out_valid(l_valid), .out_instr(l_instr), .out_class(l_class),
        .instr_count(l_count), .done(l_done));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    // Reference encoding for the default parameter set (8/4 weights, full masks).
    function automatic word_t model_word(input logic [63:0] r);
        logic [11:0] imm;
        logic [11:0] imm_e;
        imm = r[33:22];
        if (r[3:0] < 4'd8) begin
            if (r[21:19] == 3'd1)      imm_e = {7'd0, imm[4:0]};
            else if (r[21:19] == 3'd5) imm_e = {1'b0, imm[10], 5'd0, imm[4:0]};
            else                       imm_e = imm;
            return {2'd1, imm_e, r[13:9], r[21:19], r[8:4], 7'h13};
        end else if (r[3:0] < 4'd12) begin
            return {2'd2, imm[11:5], r[18:14], r[13:9], 3'b000, imm[4:0], 7'h23};
        end
        return {2'd3, imm, r[13:9], r[34], 2'b00, r[8:4], 7'h03};
    endfunction

    task automatic push_model(input int n);
        for (int i = 0; i < n; i++) begin
            m_lfsr = model_step(m_lfsr);
            exp_q.push_back(model_word(m_lfsr));
        end
    endtask

    task automatic push_nops(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({2'd0, 32'h00000013});
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 300 && m_pops < n; i++) @(posedge clk);
        check("main_pop_timeout", 64'(m_pops >= n), 64'd1);
    endtask

    always @(negedge clk) begin : main_monitor
        word_t w;
        if (reset && m_valid && rdy_m) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL main_queue: got word %0h with no expected entry", m_instr);
            end else begin
                w = exp_q.pop_front();
                check("main_instr", 64'(m_instr), 64'(w.instr));
                check("main_class", 64'(m_class), 64'(w.cls));
            end
            m_pops++;
        end
    end

    always @(negedge clk) begin
        if (reset && d_valid && rdy_d && d_class != 2'd0) d_rand++;
    end

    always @(negedge clk) begin
        if (reset && a_valid && rdy_a && a_class != 2'd0) begin
            a_words++;
            check("alu_opcode", 64'(a_instr[6:0]), 64'h13);
            check("alu_class", 64'(a_class), 64'd1);
            if (a_instr[14:12] == 3'd1) begin
                a_f3_1++;
                check("alu_slli_imm_hi", 64'(a_instr[31:25]), 64'd0);
            end
            if (a_instr[14:12] == 3'd5)
                check("alu_srxi_imm_hi", 64'(a_instr[31:25] & 7'h5F), 64'd0);
        end
    end

    always @(negedge clk) begin
        if (reset && l_valid && rdy_l && l_class != 2'd0) begin
            l_words++;
            check("ld_opcode", 64'(l_instr[6:0]), 64'h03);
            check("ld_class", 64'(l_class), 64'd3);
            check("ld_f3_low", 64'(l_instr[13:12]), 64'd0);
            check("ld_rd_window", 64'(l_instr[11:10]), 64'd0);
            check("ld_rs1_window", 64'(l_instr[19:18]), 64'd0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_instr;
        logic [31:0] held_cnt;
        int          base;
        reset     = 1'b0;
        seed_load = 1'b0;
        seed_in   = 64'd0;
        rdy_m = 1'b0; rdy_d = 1'b0; rdy_a = 1'b0; rdy_l = 1'b0;

        // SEED 0x104 steps to 0x208, 0x410, 0x820, 0x1040.
        push_nops(4);
        exp_q.push_back({2'd2, 32'h00008023});
        exp_q.push_back({2'd1, 32'h00010093});
        exp_q.push_back({2'd1, 32'h00020113});
        exp_q.push_back({2'd1, 32'h00040213});
        m_lfsr = 64'h1040;
        push_model(150);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_instr", 64'(m_instr), 64'h13);
        check("rst_class", 64'(m_class), 64'd0);
        check("rst_count", 64'(m_count), 64'd0);
        check("rst_done", 64'(m_done), 64'd0);

        reset = 1'b1;
        rdy_m = 1'b1; rdy_d = 1'b1; rdy_a = 1'b1; rdy_l = 1'b1;
        @(posedge clk);
        #1;
        check("valid_after_reset", 64'(m_valid), 64'd1);

        wait_pops(5);
        #1;
        check("count_after_first", 64'(m_count), 64'd1);
        check("budget_done_early", 64'(d_done), 64'd0);
        check("budget_count_early", 64'(d_count), 64'd1);

        wait_pops(8);
        #1;
        rdy_m      = 1'b0;
        held_instr = m_instr;
        held_cnt   = m_count;
        check("stall_count_entry", 64'(held_cnt), 64'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_instr", 64'(m_instr), 64'(held_instr));
            check("stall_count", 64'(m_count), 64'(held_cnt));
            check("stall_valid", 64'(m_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        rdy_m = 1'b1;

        wait_pops(20);
        #1;
        seed_load = 1'b1;
        seed_in   = 64'd0;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        check("seed_count", 64'(m_count), 64'd0);
        check("seed_done", 64'(m_done), 64'd0);
        check("seed_instr", 64'(m_instr), 64'h13);
        check("seed_class", 64'(m_class), 64'd0);
        check("seed_valid", 64'(m_valid), 64'd1);
        // Fresh SEED=1 stream: states 2, 4, 8, 0x10, 0x20.
        exp_q.delete();
        push_nops(4);
        exp_q.push_back({2'd1, 32'h00000013});
        exp_q.push_back({2'd1, 32'h00000013});
        exp_q.push_back({2'd2, 32'h00000023});
        exp_q.push_back({2'd1, 32'h00000093});
        exp_q.push_back({2'd1, 32'h00000113});
        m_lfsr = 64'h20;
        push_model(20);
        base = m_pops;
        wait_pops(base + 9);
        #1;
        check("seed_count_resume", 64'(m_count), 64'd5);
        rdy_m = 1'b0;

        for (int i = 0; i < 300 && !d_done; i++) @(posedge clk);
        #1;
        check("budget_done", 64'(d_done), 64'd1);
        check("budget_count", 64'(d_count), 64'd10);
        check("budget_accepted", 64'(d_rand), 64'd10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("done_instr", 64'(d_instr), 64'h13);
            check("done_class", 64'(d_class), 64'd0);
            check("done_valid", 64'(d_valid), 64'd1);
            check("done_count", 64'(d_count), 64'd10);
        end

        for (int i = 0; i < 3000 && (a_words < 200 || l_words < 200); i++) @(posedge clk);
        check("alu_words_seen", 64'(a_words >= 200), 64'd1);
        check("ld_words_seen", 64'(l_words >= 200), 64'd1);
        check("alu_f3_1_seen", 64'(a_f3_1 != 0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
